// File: rtl/vrf_read_sequencer_pkg.sv
// rtl/vrf_read_sequencer_pkg.sv - shared vector-core types and width helpers
package vrf_read_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } vrs_state_e;

  // Words per vector register segment
  function automatic int seg_words(input int mem_depth, input int vreg_num);
    return mem_depth / vreg_num;
  endfunction

  // Address width for a memory of the given depth (at least one bit)
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Vector register index width
  function automatic int vreg_w(input int vreg_num);
    return (vreg_num > 1) ? $clog2(vreg_num) : 1;
  endfunction

  // Request length width: must hold the value SEG itself
  function automatic int len_w(input int mem_depth, input int vreg_num);
    return $clog2(seg_words(mem_depth, vreg_num)) + 1;
  endfunction

  // Occupancy counter width: must hold the value depth itself
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word fall-through synchronous FIFO with occupancy count
module sync_fifo_fwft
  import vrf_read_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     s_tvalid,
  input  logic [WIDTH-1:0]         s_tdata,
  output logic                     m_tvalid,
  output logic [WIDTH-1:0]         m_tdata,
  input  logic                     m_tready,
  output logic [cnt_w(DEPTH)-1:0]  count
);

  localparam int PW = addr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  // The writer guarantees space (credit-based), so there is no ready back to it.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign m_tvalid = (count != '0);
  assign do_pop   = m_tvalid && m_tready;
  // Head is forced to zero when empty so the outputs are clean after reset
  assign m_tdata  = m_tvalid ? mem_q[rd_ptr_q] : '0;

  // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count    <= '0;
    end else begin
      if (s_tvalid) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)   rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({s_tvalid, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; when full with a simultaneous pop the head slot is reused safely
  always_ff @(posedge clk) begin
    if (s_tvalid) mem_q[wr_ptr_q] <= s_tdata;
  end

endmodule

// File: rtl/vrf_read_sequencer.sv
// rtl/vrf_read_sequencer.sv - credit-based VRF operand read sequencer with output buffer
module vrf_read_sequencer
  import vrf_read_sequencer_pkg::*;
#(
  parameter int MEM_DEPTH    = 512,
  parameter int MEM_WIDTH    = 32,
  parameter int VREG_NUM     = 32,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  req_valid_i,
  output logic                                  req_ready_o,
  input  logic [vreg_w(VREG_NUM)-1:0]           req_vreg_i,
  input  logic [len_w(MEM_DEPTH,VREG_NUM)-1:0]  req_len_i,
  output logic [addr_w(MEM_DEPTH)-1:0]          raddr_o,
  output logic                                  ren_o,
  output logic                                  oreg_en_o,
  input  logic [MEM_WIDTH-1:0]                  rdata_i,
  output logic                                  dout_valid_o,
  input  logic                                  dout_ready_i,
  output logic [MEM_WIDTH-1:0]                  dout_data_o,
  output logic                                  dout_last_o,
  output logic                                  busy_o
);

  localparam int SEG = seg_words(MEM_DEPTH, VREG_NUM);
  localparam int AW  = addr_w(MEM_DEPTH);
  localparam int LW  = len_w(MEM_DEPTH, VREG_NUM);
  localparam int CW  = cnt_w(FIFO_DEPTH);

  vrs_state_e              state_q, state_d;
  logic [AW-1:0]           base_q, raddr_q, raddr_now;
  logic [LW-1:0]           len_q, idx_q, len_clamp;
  logic [CW-1:0]           outst_q, fifo_cnt;
  logic [CW:0]             inflight;
  logic [READ_LATENCY-1:0] pipe_v, pipe_l;
  logic                    accept, issue_last, credit_ok, cap, pop, idx_at_end;
  logic [MEM_WIDTH:0]      head;

  assign len_clamp  = (req_len_i > LW'(SEG)) ? LW'(SEG) : req_len_i;
  assign inflight   = {1'b0, outst_q} + {1'b0, fifo_cnt};
  assign credit_ok  = (inflight < (CW+1)'(FIFO_DEPTH));
  assign idx_at_end = (idx_q == len_q - LW'(1));
  assign raddr_now  = base_q + AW'(idx_q);
  assign raddr_o    = ren_o ? raddr_now : raddr_q;
  assign issue_last = ren_o && idx_at_end;
  assign cap        = pipe_v[READ_LATENCY-1];
  assign pop        = dout_valid_o && dout_ready_i;
  assign oreg_en_o  = (READ_LATENCY == 2) ? pipe_v[0] : ren_o;
  assign busy_o     = (state_q != ST_IDLE) || (fifo_cnt != '0);

  // Next-state and handshake decode; reads issue only while credit allows
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    ren_o       = 1'b0;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          accept = 1'b1;
          if (len_clamp != '0) state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (credit_ok) begin
          ren_o = 1'b1;
          if (idx_at_end) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((outst_q == '0) && ((fifo_cnt == '0) || ((fifo_cnt == CW'(1)) && pop)))
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request context: base/len latched on accept, index advances per issued read
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        base_q <= AW'(req_vreg_i) * AW'(SEG);
        len_q  <= len_clamp;
        idx_q  <= '0;
      end
      if (ren_o) begin
        idx_q   <= idx_q + LW'(1);
        raddr_q <= raddr_now;
      end
    end
  end

  // Reads issued but not yet captured into the FIFO
  always_ff @(posedge clk) begin
    if (!rstn) begin
      outst_q <= '0;
    end else begin
      case ({ren_o, cap})
        2'b10:   outst_q <= outst_q + CW'(1);
        2'b01:   outst_q <= outst_q - CW'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  // Latency pipe: valid and last flags travel with each read until capture
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pipe_v <= '0;
      pipe_l <= '0;
    end else begin
      pipe_v[0] <= ren_o;
      pipe_l[0] <= issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_l[i] <= pipe_l[i-1];
      end
    end
  end

  sync_fifo_fwft #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (MEM_WIDTH + 1)
  ) u_out_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .s_tvalid (cap),
    .s_tdata  ({pipe_l[READ_LATENCY-1], rdata_i}),
    .m_tvalid (dout_valid_o),
    .m_tdata  (head),
    .m_tready (dout_ready_i),
    .count    (fifo_cnt)
  );

  assign dout_data_o = head[MEM_WIDTH-1:0];
  assign dout_last_o = head[MEM_WIDTH];

endmodule

// File: tb/tb_vrf_read_sequencer.sv
// tb/tb_vrf_read_sequencer.sv - directed self-checking bench for vrf_read_sequencer
module tb_vrf_read_sequencer;

  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic [4:0]  req_vreg = '0;
  logic [4:0]  req_len = '0;
  logic        dout_ready = 1'b0;

  logic        req_ready1, ren1, oreg1, dvalid1, dlast1, busy1;
  logic        req_ready2, ren2, oreg2, dvalid2, dlast2, busy2;
  logic [8:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2, ddata1, ddata2;
  logic [31:0] ram_q1, ram_q2, out_q2;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [32:0] beats [2][64];
  logic [8:0]  addrs [2][64];
  int          acyc  [2][64];
  int          nb [2];
  int          na [2];
  int          oreg_err [2];
  logic        prev_ren2 = 1'b0;
  logic        mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] vdata(input logic [8:0] a);
    return 32'h5A00_0000 ^ {7'd0, a, 7'd0, a};
  endfunction

  vrf_read_sequencer #(.READ_LATENCY(1), .FIFO_DEPTH(FD)) u_dut1 (
    .clk(clk), .rstn(rstn), .req_valid_i(req_valid), .req_ready_o(req_ready1),
    .req_vreg_i(req_vreg), .req_len_i(req_len), .raddr_o(raddr1), .ren_o(ren1),
    .oreg_en_o(oreg1), .rdata_i(rdata1), .dout_valid_o(dvalid1), .dout_ready_i(dout_ready),
    .dout_data_o(ddata1), .dout_last_o(dlast1), .busy_o(busy1)
  );

  vrf_read_sequencer #(.READ_LATENCY(2), .FIFO_DEPTH(FD)) u_dut2 (
    .clk(clk), .rstn(rstn), .req_valid_i(req_valid), .req_ready_o(req_ready2),
    .req_vreg_i(req_vreg), .req_len_i(req_len), .raddr_o(raddr2), .ren_o(ren2),
    .oreg_en_o(oreg2), .rdata_i(rdata2), .dout_valid_o(dvalid2), .dout_ready_i(dout_ready),
    .dout_data_o(ddata2), .dout_last_o(dlast2), .busy_o(busy2)
  );

  // VRF lane models: latency 1 uses the array register only, latency 2 adds the output register
  always @(posedge clk) begin
    if (ren1) ram_q1 <= vdata(raddr1);
    if (ren2) ram_q2 <= vdata(raddr2);
    if (oreg2) out_q2 <= ram_q2;
  end
  assign rdata1 = ram_q1;
  assign rdata2 = out_q2;

  // Log issued addresses, delivered beats and output-register enable timing
  always @(negedge clk) begin
    if (mon_en) begin
      if (dvalid1 && dout_ready && nb[0] < 64) begin beats[0][nb[0]] = {dlast1, ddata1}; nb[0]++; end
      if (dvalid2 && dout_ready && nb[1] < 64) begin beats[1][nb[1]] = {dlast2, ddata2}; nb[1]++; end
      if (ren1 && na[0] < 64) begin addrs[0][na[0]] = raddr1; acyc[0][na[0]] = cyc; na[0]++; end
      if (ren2 && na[1] < 64) begin addrs[1][na[1]] = raddr2; acyc[1][na[1]] = cyc; na[1]++; end
      if (oreg1 !== ren1) oreg_err[0]++;
      if (oreg2 !== prev_ren2) oreg_err[1]++;
      prev_ren2 = ren2 && rstn;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    nb[0] = 0; nb[1] = 0; na[0] = 0; na[1] = 0;
  endtask

  task automatic send_req(input int vreg, input int len);
    int n = 0;
    @(negedge clk);
    while (!(req_ready1 && req_ready2) && n < 200) begin @(negedge clk); n++; end
    tests++;
    if (!(req_ready1 && req_ready2)) begin
      fails++;
      $display("FAIL send_req_ready: ready1=%0b ready2=%0b after %0d cycles, expected 1/1", req_ready1, req_ready2, n);
    end
    tick();
    req_valid = 1'b1; req_vreg = 5'(vreg); req_len = 5'(len);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n = 0;
    @(negedge clk);
    while ((busy1 || busy2) && n < bound) begin @(negedge clk); n++; end
    tests++;
    if (busy1 || busy2) begin
      fails++;
      $display("FAIL %s_idle_timeout: busy1=%0b busy2=%0b after %0d cycles, expected 0/0", tag, busy1, busy2, n);
    end
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = 1'b0; dout_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    tests += 10;
    if (req_ready2 !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %0b, expected 1", req_ready2); end
    if (ren2 !== 1'b0)       begin fails++; $display("FAIL reset_ren: got %0b, expected 0", ren2); end
    if (oreg2 !== 1'b0)      begin fails++; $display("FAIL reset_oreg_en: got %0b, expected 0", oreg2); end
    if (raddr2 !== 9'd0)     begin fails++; $display("FAIL reset_raddr: got %0d, expected 0", raddr2); end
    if (dvalid2 !== 1'b0)    begin fails++; $display("FAIL reset_dout_valid: got %0b, expected 0", dvalid2); end
    if (dlast2 !== 1'b0)     begin fails++; $display("FAIL reset_dout_last: got %0b, expected 0", dlast2); end
    if (ddata2 !== 32'd0)    begin fails++; $display("FAIL reset_dout_data: got %h, expected 0", ddata2); end
    if (busy2 !== 1'b0)      begin fails++; $display("FAIL reset_busy: got %0b, expected 0", busy2); end
    if (busy1 !== 1'b0)      begin fails++; $display("FAIL reset_busy_l1: got %0b, expected 0", busy1); end
    if (ren1 !== 1'b0)       begin fails++; $display("FAIL reset_ren_l1: got %0b, expected 0", ren1); end
    tick();
    rstn = 1'b1;
    mon_en = 1'b1;
    oreg_err[0] = 0; oreg_err[1] = 0;
    clear_logs();
  endtask

  task automatic test_basic();
    logic [32:0] exp;
    clear_logs();
    dout_ready = 1'b1;
    send_req(3, 16);
    wait_idle(200, "basic");
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (na[d] != 16) begin fails++; $display("FAIL basic_issue_count L%0d: got %0d, expected 16", d+1, na[d]); end
      for (int k = 0; k < na[d] && k < 16; k++) begin
        tests++;
        if (addrs[d][k] !== 9'(48 + k)) begin fails++; $display("FAIL basic_raddr L%0d[%0d]: got %0d, expected %0d", d+1, k, addrs[d][k], 48 + k); end
      end
      if (na[d] >= 16) begin
        tests++;
        if (acyc[d][15] - acyc[d][0] != 15) begin fails++; $display("FAIL basic_consecutive L%0d: span %0d cycles, expected 15", d+1, acyc[d][15] - acyc[d][0]); end
      end
      tests++;
      if (nb[d] != 16) begin fails++; $display("FAIL basic_beat_count L%0d: got %0d, expected 16", d+1, nb[d]); end
      for (int k = 0; k < nb[d] && k < 16; k++) begin
        exp = {(k == 15), vdata(9'(48 + k))};
        tests++;
        if (beats[d][k] !== exp) begin fails++; $display("FAIL basic_beat L%0d[%0d]: got %h, expected %h", d+1, k, beats[d][k], exp); end
      end
    end
    tests++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0) begin fails++; $display("FAIL basic_busy_after: got %0b/%0b, expected 0/0", busy1, busy2); end
  endtask

  task automatic test_len_zero();
    clear_logs();
    dout_ready = 1'b1;
    send_req(5, 0);
    @(negedge clk);
    tests += 3;
    if (req_ready2 !== 1'b1) begin fails++; $display("FAIL len0_ready_next L2: got %0b, expected 1", req_ready2); end
    if (req_ready1 !== 1'b1) begin fails++; $display("FAIL len0_ready_next L1: got %0b, expected 1", req_ready1); end
    if (busy2 !== 1'b0)      begin fails++; $display("FAIL len0_busy: got %0b, expected 0", busy2); end
    repeat (6) tick();
    for (int d = 0; d < 2; d++) begin
      tests += 2;
      if (na[d] != 0) begin fails++; $display("FAIL len0_no_ren L%0d: got %0d reads, expected 0", d+1, na[d]); end
      if (nb[d] != 0) begin fails++; $display("FAIL len0_no_beat L%0d: got %0d beats, expected 0", d+1, nb[d]); end
    end
  endtask

  task automatic test_clamp();
    logic [32:0] exp;
    clear_logs();
    dout_ready = 1'b1;
    send_req(31, 20);
    wait_idle(200, "clamp");
    for (int d = 0; d < 2; d++) begin
      tests += 2;
      if (na[d] != 16) begin fails++; $display("FAIL clamp_issue_count L%0d: got %0d, expected 16", d+1, na[d]); end
      if (nb[d] != 16) begin fails++; $display("FAIL clamp_beat_count L%0d: got %0d, expected 16", d+1, nb[d]); end
      for (int k = 0; k < na[d] && k < 20; k++) begin
        tests++;
        if (addrs[d][k] !== 9'(496 + k)) begin fails++; $display("FAIL clamp_raddr L%0d[%0d]: got %0d, expected %0d", d+1, k, addrs[d][k], 496 + k); end
      end
      for (int k = 0; k < nb[d] && k < 20; k++) begin
        exp = {(k == 15), vdata(9'(496 + k))};
        tests++;
        if (beats[d][k] !== exp) begin fails++; $display("FAIL clamp_beat L%0d[%0d]: got %h, expected %h", d+1, k, beats[d][k], exp); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] exp;
    clear_logs();
    dout_ready = 1'b0;
    send_req(2, 8);
    repeat (15) tick();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (na[d] != FD) begin fails++; $display("FAIL bp_stall_reads L%0d: got %0d, expected %0d", d+1, na[d], FD); end
    end
    @(negedge clk);
    tests += 4;
    if (ren2 !== 1'b0)               begin fails++; $display("FAIL bp_ren_stalled: got %0b, expected 0", ren2); end
    if (dvalid2 !== 1'b1)            begin fails++; $display("FAIL bp_head_valid: got %0b, expected 1", dvalid2); end
    if (ddata2 !== vdata(9'd32))     begin fails++; $display("FAIL bp_head_data: got %h, expected %h", ddata2, vdata(9'd32)); end
    if (raddr2 !== 9'd35)            begin fails++; $display("FAIL bp_raddr_hold: got %0d, expected 35", raddr2); end
    tick();
    dout_ready = 1'b1;
    wait_idle(200, "bp");
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (nb[d] != 8) begin fails++; $display("FAIL bp_beat_count L%0d: got %0d, expected 8", d+1, nb[d]); end
      for (int k = 0; k < nb[d] && k < 8; k++) begin
        exp = {(k == 7), vdata(9'(32 + k))};
        tests++;
        if (beats[d][k] !== exp) begin fails++; $display("FAIL bp_beat L%0d[%0d]: got %h, expected %h", d+1, k, beats[d][k], exp); end
      end
    end
  endtask

  task automatic test_random_ready();
    logic [32:0] exp;
    int n = 0;
    clear_logs();
    dout_ready = 1'b0;
    send_req(7, 16);
    do begin
      tick();
      dout_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end while ((busy1 || busy2) && n < 400);
    tests++;
    if (busy1 || busy2) begin fails++; $display("FAIL rand_idle_timeout: busy1=%0b busy2=%0b, expected 0/0", busy1, busy2); end
    dout_ready = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (nb[d] != 16) begin fails++; $display("FAIL rand_beat_count L%0d: got %0d, expected 16", d+1, nb[d]); end
      for (int k = 0; k < nb[d] && k < 16; k++) begin
        exp = {(k == 15), vdata(9'(112 + k))};
        tests++;
        if (beats[d][k] !== exp) begin fails++; $display("FAIL rand_beat L%0d[%0d]: got %h, expected %h", d+1, k, beats[d][k], exp); end
      end
      tests++;
      if (oreg_err[d] != 0) begin fails++; $display("FAIL oreg_en_timing L%0d: got %0d bad cycles, expected 0", d+1, oreg_err[d]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [32:0] exp;
    int n = 0;
    clear_logs();
    dout_ready = 1'b1;
    send_req(4, 16);
    while (na[1] < 5 && n < 50) begin tick(); n++; end
    tests++;
    if (na[1] < 5) begin fails++; $display("FAIL rstmid_progress: got %0d reads, expected at least 5", na[1]); end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    tests += 9;
    if (req_ready2 !== 1'b1) begin fails++; $display("FAIL rstmid_req_ready: got %0b, expected 1", req_ready2); end
    if (ren2 !== 1'b0)       begin fails++; $display("FAIL rstmid_ren: got %0b, expected 0", ren2); end
    if (oreg2 !== 1'b0)      begin fails++; $display("FAIL rstmid_oreg_en: got %0b, expected 0", oreg2); end
    if (raddr2 !== 9'd0)     begin fails++; $display("FAIL rstmid_raddr: got %0d, expected 0", raddr2); end
    if (dvalid2 !== 1'b0)    begin fails++; $display("FAIL rstmid_dout_valid: got %0b, expected 0", dvalid2); end
    if (dlast2 !== 1'b0)     begin fails++; $display("FAIL rstmid_dout_last: got %0b, expected 0", dlast2); end
    if (ddata2 !== 32'd0)    begin fails++; $display("FAIL rstmid_dout_data: got %h, expected 0", ddata2); end
    if (busy2 !== 1'b0)      begin fails++; $display("FAIL rstmid_busy: got %0b, expected 0", busy2); end
    if (busy1 !== 1'b0)      begin fails++; $display("FAIL rstmid_busy_l1: got %0b, expected 0", busy1); end
    tick();
    clear_logs();
    repeat (6) tick();
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (nb[d] != 0 || na[d] != 0) begin fails++; $display("FAIL rstmid_stale L%0d: got %0d beats %0d reads, expected 0/0", d+1, nb[d], na[d]); end
    end
    send_req(6, 4);
    wait_idle(100, "rstmid");
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (nb[d] != 4) begin fails++; $display("FAIL rstmid_next_count L%0d: got %0d, expected 4", d+1, nb[d]); end
      for (int k = 0; k < nb[d] && k < 4; k++) begin
        exp = {(k == 3), vdata(9'(96 + k))};
        tests++;
        if (beats[d][k] !== exp) begin fails++; $display("FAIL rstmid_next_beat L%0d[%0d]: got %h, expected %h", d+1, k, beats[d][k], exp); end
      end
    end
  endtask

  initial begin
    clear_logs();
    oreg_err[0] = 0; oreg_err[1] = 0;
    test_reset();
    test_basic();
    test_len_zero();
    test_clamp();
    test_backpressure();
    test_random_ready();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

endmodule

// File: doc/vrf_read_sequencer.md
VRF_READ_SEQUENCER -- requirements
Module: vrf_read_sequencer

Interface
REQ-001 Parameter MEM_DEPTH, default 512, total words in one VRF lane.
REQ-002 Parameter MEM_WIDTH, default 32, data word width in bits.
REQ-003 Parameter VREG_NUM, default 32, number of vector registers; SEG = MEM_DEPTH/VREG_NUM words per register.
REQ-004 Parameter READ_LATENCY, default 2, cycles from ren_o to valid rdata_i; legal values are 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 4, output buffer entries; must be at least READ_LATENCY+1.
REQ-006 clk  in  1  clock; all logic is on posedge clk.
REQ-007 rstn  in  1  synchronous active-low reset.
REQ-008 req_valid_i  in  1  operand read request valid.
REQ-009 req_ready_o  out  1  request accepted when valid&&ready.
REQ-010 req_vreg_i  in  clog2(VREG_NUM)  source vector register index.
REQ-011 req_len_i  in  clog2(SEG)+1  number of words to read.
REQ-012 raddr_o  out  clog2(MEM_DEPTH)  VRF read-port address.
REQ-013 ren_o  out  1  VRF read-port enable.
REQ-014 oreg_en_o  out  1  VRF output-register enable.
REQ-015 rdata_i  in  MEM_WIDTH  VRF read-port data.
REQ-016 dout_valid_o / dout_ready_i  out / in  1 / 1  output stream handshake.
REQ-017 dout_data_o  out  MEM_WIDTH  output word.
REQ-018 dout_last_o  out  1  marks the final word of a request.
REQ-019 busy_o  out  1  high when state is not IDLE or the FIFO is non-empty.

Function
REQ-020 The FSM SHALL have three states, IDLE, ISSUE and DRAIN; req_ready_o is high only in IDLE.
REQ-021 On acceptance, the block SHALL latch the base address vreg*SEG and len' = min(req_len_i, SEG), then go to ISSUE; if len' is 0 it stays in IDLE and produces no beat.
REQ-022 In ISSUE, the block SHALL assert ren_o with raddr_o = base+idx when outstanding+fifo_count < FIFO_DEPTH, and increment idx.
REQ-023 After issuing idx = len'-1, the FSM SHALL go to DRAIN; from DRAIN it returns to IDLE once outstanding = 0, the FIFO is empty and the last beat has been handshaken.
REQ-024 If the credit check fails, the block SHALL deassert ren_o and hold idx; raddr_o holds its value.
REQ-025 oreg_en_o SHALL equal ren_o delayed by one cycle when READ_LATENCY=2, and equal ren_o when READ_LATENCY=1.
REQ-026 rdata_i SHALL be pushed into the FIFO exactly READ_LATENCY cycles after each ren_o, tracked by a shift register of valid bits; the last flag travels alongside.
REQ-027 outstanding SHALL count issued reads not yet captured; it increments on issue and decrements on capture, both in the same cycle if simultaneous.
REQ-028 dout_* SHALL present the FIFO head; a pop occurs on valid&&ready.
REQ-029 A push and pop in the same cycle SHALL leave the count unchanged, including when the FIFO is full; the credit rule guarantees no overflow.
REQ-030 No read data is lost or reordered under any dout_ready_i pattern.
REQ-031 Address arithmetic SHALL be unsigned at clog2(MEM_DEPTH) width; base+len'-1 never exceeds the register's segment.

Reset
REQ-032 When rstn=0, the block SHALL go to IDLE and clear idx, outstanding, the latency pipe and the FIFO; in-flight reads are discarded.
REQ-033 Reset values SHALL be: req_ready_o=1 after reset, ren_o=0, oreg_en_o=0, raddr_o=0, dout_valid_o=0, dout_last_o=0, dout_data_o=0, busy_o=0.
REQ-034 Reset asserted mid-request SHALL take effect on the next edge; data returned afterwards is ignored.

Structure
REQ-035 MEM_DEPTH/VREG_NUM-derived widths and the FSM state enum SHALL live in the shared vector-core package.
REQ-036 The output buffer SHALL be a separate sub-module, sync_fifo_fwft (first-word fall-through, parameterised depth and width, count output).

Verification
REQ-037 Scenario: vreg=3, len=16, dout_ready=1 -> raddr 48..63 on consecutive cycles; 16 beats in order; last on beat 16; busy low after.
REQ-038 Scenario: len=0 -> ren_o never asserted; no dout beat; req_ready_o high the next cycle.
REQ-039 Scenario: len=20 -> clamped to 16 beats; raddr never exceeds base+15.
REQ-040 Scenario: dout_ready=0 throughout, len=8 -> exactly FIFO_DEPTH reads issued, then ren_o stalls; releasing ready delivers all 8 words intact.
REQ-041 Scenario: random dout_ready at 50%, len=16, READ_LATENCY 1 and 2 -> data matches the model; oreg_en_o timing per REQ-025.
REQ-042 Scenario: rstn pulsed low for 1 cycle after 5 of 16 reads -> all outputs at reset values; the following request behaves normally with no stale beats.
